// File: rtl/prbs_rx_chk.sv
// prbs_rx_chk - parametrised PRBS receive checker (REC_CLK domain).
//
// Checks received words against a Fibonacci LFSR reference, sequences
// lock acquisition/loss (HUNT -> ACQ -> LOCK), resynchronises on the start
// pattern and keeps saturating word / errored-word / bit-error counters.
//
// Ports:
//   REC_CLK    receive clock, rising edge
//   RST        asynchronous active-high reset
//   CE         word strobe, RCV_DATA sampled only when CE=1
//   CLR_CNT    synchronous clear of the three counters
//   RCV_DATA   received word (DATA_W)
//   STRT_MTCH  combinational RCV_DATA == START_PAT
//   VALID      one-clock strobe for a checked word result
//   MATCH      result of the last checked word, held between VALIDs
//   LOCKED     FSM is in LOCK
//   WORD_CNT   checked words (saturating)
//   ERR_WORDS  mismatched checked words (saturating)
//   ERR_BITS   accumulated bit errors (saturating)
module prbs_rx_chk #(
  parameter int                DATA_W    = 48,
  parameter int                LFSR_W    = 24,
  parameter logic [LFSR_W-1:0] TAPS      = 24'hE10000,
  parameter logic [LFSR_W-1:0] SEED      = 24'h83B62E,
  parameter logic [DATA_W-1:0] START_PAT = 48'hFFFFFF000000,
  parameter int                LOSS_THR  = 4,
  parameter int                CNT_W     = 32
) (
  input  logic              REC_CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic              CLR_CNT,
  input  logic [DATA_W-1:0] RCV_DATA,
  output logic              STRT_MTCH,
  output logic              VALID,
  output logic              MATCH,
  output logic              LOCKED,
  output logic [CNT_W-1:0]  WORD_CNT,
  output logic [CNT_W-1:0]  ERR_WORDS,
  output logic [CNT_W-1:0]  ERR_BITS
);

  localparam int unsigned K     = DATA_W / LFSR_W;
  localparam int          PC_W  = $clog2(DATA_W + 1);
  localparam int          SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [3:0]  THR   = 4'(LOSS_THR);

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [3:0]        miss_cnt, miss_nxt, miss_inc;
  logic [LFSR_W-1:0] lfsr, lfsr_adv, unroll_st;
  logic [DATA_W-1:0] exp_word;

  logic              s1_vld;
  logic [DATA_W-1:0] s1_data, s1_exp;

  logic [DATA_W-1:0] diff;
  logic              word_ok, loss, start_ev, capture;
  logic [PC_W-1:0]   popcnt;
  logic [SUM_W-1:0]  bits_sum;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & TAPS)};
  endfunction

  assign STRT_MTCH = (RCV_DATA == START_PAT);
  assign LOCKED    = (state == ST_LOCK);

  // K LFSR steps unrolled: first state lands in the MSBs of the word.
  always_comb begin
    exp_word  = '0;
    unroll_st = lfsr;
    for (int unsigned k = 0; k < K; k++) begin
      exp_word[DATA_W-1-k*LFSR_W -: LFSR_W] = unroll_st;
      unroll_st = lfsr_step(unroll_st);
    end
    lfsr_adv = unroll_st;
  end

  // Stage-2 compare
  always_comb begin
    diff    = s1_data ^ s1_exp;
    word_ok = (diff == '0);
    popcnt  = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      popcnt = popcnt + PC_W'(diff[i]);
    end
    bits_sum = SUM_W'(ERR_BITS) + SUM_W'(popcnt);
  end

  // FSM / mismatch counter. A start pattern on the same edge as a loss keeps
  // the link out of HUNT, since the LFSR is being reseeded on that edge.
  always_comb begin
    state_nxt = state;
    miss_inc  = miss_cnt + 4'd1;
    miss_nxt  = miss_cnt;
    start_ev  = CE && STRT_MTCH;
    loss      = s1_vld && !word_ok && (miss_inc >= THR);
    if (s1_vld) begin
      if (word_ok) begin
        miss_nxt = '0;
        if (state == ST_ACQ) state_nxt = ST_LOCK;
      end else if (loss) begin
        miss_nxt  = '0;
        state_nxt = ST_HUNT;
      end else begin
        miss_nxt = miss_inc;
      end
    end
    if (start_ev) begin
      miss_nxt = '0;
      if (state_nxt == ST_HUNT) state_nxt = ST_ACQ;
    end
    // A word arriving on the edge that drops to HUNT is discarded.
    capture = CE && !STRT_MTCH && (state != ST_HUNT) && !loss;
  end

  always_ff @(posedge REC_CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_HUNT;
      miss_cnt <= '0;
      lfsr     <= SEED;
      s1_vld   <= 1'b0;
      s1_data  <= '0;
      s1_exp   <= '0;
    end else begin
      state    <= state_nxt;
      miss_cnt <= miss_nxt;
      s1_vld   <= capture;
      if (start_ev) begin
        lfsr <= SEED;
      end else if (capture) begin
        lfsr <= lfsr_adv;
      end
      if (capture) begin
        s1_data <= RCV_DATA;
        s1_exp  <= exp_word;
      end
    end
  end

  always_ff @(posedge REC_CLK or posedge RST) begin
    if (RST) begin
      VALID <= 1'b0;
      MATCH <= 1'b0;
    end else begin
      VALID <= s1_vld;
      if (s1_vld) MATCH <= word_ok;
    end
  end

  always_ff @(posedge REC_CLK or posedge RST) begin
    if (RST) begin
      WORD_CNT  <= '0;
      ERR_WORDS <= '0;
      ERR_BITS  <= '0;
    end else if (CLR_CNT) begin
      WORD_CNT  <= '0;
      ERR_WORDS <= '0;
      ERR_BITS  <= '0;
    end else if (s1_vld) begin
      if (WORD_CNT != '1) WORD_CNT <= WORD_CNT + 1'b1;
      if (!word_ok && (ERR_WORDS != '1)) ERR_WORDS <= ERR_WORDS + 1'b1;
      if (bits_sum > SUM_W'({CNT_W{1'b1}})) begin
        ERR_BITS <= '1;
      end else begin
        ERR_BITS <= bits_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_prbs_rx_chk.sv
module tb_prbs_rx_chk;

  localparam logic [23:0] TAPS  = 24'hE10000;
  localparam logic [23:0] SEED  = 24'h83B62E;
  localparam logic [47:0] START = 48'hFFFFFF000000;
  localparam int KG = 0;  // next reference word (optionally corrupted)
  localparam int KS = 1;  // start pattern
  localparam int KI = 2;  // no CE

  logic REC_CLK = 1'b0;
  always #5 REC_CLK = ~REC_CLK;

  logic        RST, ce, clr, ce_s, clr_s;
  logic [47:0] data, data_s;
  logic        strt, valid, match, locked;
  logic        strt_s, valid_s, match_s, locked_s;
  logic [31:0] wc, ew, eb;
  logic [3:0]  wc_s, ew_s, eb_s;

  prbs_rx_chk u_dut (
    .REC_CLK(REC_CLK), .RST(RST), .CE(ce), .CLR_CNT(clr), .RCV_DATA(data),
    .STRT_MTCH(strt), .VALID(valid), .MATCH(match), .LOCKED(locked),
    .WORD_CNT(wc), .ERR_WORDS(ew), .ERR_BITS(eb)
  );

  prbs_rx_chk #(.LOSS_THR(15), .CNT_W(4)) u_sat (
    .REC_CLK(REC_CLK), .RST(RST), .CE(ce_s), .CLR_CNT(clr_s), .RCV_DATA(data_s),
    .STRT_MTCH(strt_s), .VALID(valid_s), .MATCH(match_s), .LOCKED(locked_s),
    .WORD_CNT(wc_s), .ERR_WORDS(ew_s), .ERR_BITS(eb_s)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] step(input logic [23:0] s);
    return {s[22:0], ^(s & TAPS)};
  endfunction

  task automatic next_word(inout logic [23:0] st, output logic [47:0] w);
    w  = {st, step(st)};
    st = step(step(st));
  endtask

  typedef struct {
    int          kind;
    logic [47:0] mask;
    logic        ev, em, el;
    bit          cc;
    int          wc, ew, eb;
  } row_t;

  row_t rows[$];

  function automatic void add(int kind, logic [47:0] mask, logic ev, logic em, logic el);
    row_t r;
    r.kind = kind; r.mask = mask; r.ev = ev; r.em = em; r.el = el;
    r.cc = 1'b0; r.wc = 0; r.ew = 0; r.eb = 0;
    rows.push_back(r);
  endfunction

  function automatic void addc(int kind, logic [47:0] mask, logic ev, logic em, logic el,
                               int wcnt, int ewrd, int ebit);
    row_t r;
    r.kind = kind; r.mask = mask; r.ev = ev; r.em = em; r.el = el;
    r.cc = 1'b1; r.wc = wcnt; r.ew = ewrd; r.eb = ebit;
    rows.push_back(r);
  endfunction

  task automatic drive(input logic c, input logic [47:0] d);
    ce = c; data = d;
    @(posedge REC_CLK); #1;
  endtask

  task automatic drive_s(input logic c, input logic [47:0] d, input logic cl);
    ce_s = c; data_s = d; clr_s = cl;
    @(posedge REC_CLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [23:0] m, ms, t;
  logic [47:0] w;

  initial begin
    // Main table: scenarios 1-4 (acquire, bit errors, resync, loss + reacquire)
    add(KS, '0, 0, 0, 0);
    add(KG, '0, 0, 0, 0);
    add(KG, '0, 1, 1, 1);
    for (int i = 0; i < 98; i++) add(KG, '0, 1, 1, 1);
    add(KI, '0, 1, 1, 1);
    addc(KI, '0, 0, 1, 1, 100, 0, 0);
    add(KG, 48'h0001_0000_0011, 0, 1, 1);
    add(KG, '0, 1, 0, 1);
    addc(KI, '0, 1, 1, 1, 102, 1, 3);
    add(KS, '0, 0, 1, 1);
    add(KG, '0, 0, 1, 1);
    add(KG, '0, 1, 1, 1);
    add(KI, '0, 1, 1, 1);
    addc(KI, '0, 0, 1, 1, 104, 1, 3);
    add(KG, 48'h0000_0000_0001, 0, 1, 1);
    add(KG, 48'h0000_0000_0020, 1, 0, 1);
    add(KG, 48'h0000_0000_0400, 1, 0, 1);
    add(KG, 48'h8000_0000_0000, 1, 0, 1);
    add(KG, '0, 1, 0, 0);
    add(KG, '0, 0, 0, 0);
    add(KI, '0, 0, 0, 0);
    addc(KI, '0, 0, 0, 0, 108, 5, 7);
    add(KS, '0, 0, 0, 0);
    add(KG, '0, 0, 0, 0);
    add(KG, '0, 1, 1, 1);
    add(KI, '0, 1, 1, 1);
    addc(KI, '0, 0, 1, 1, 110, 5, 7);

    ce = 0; clr = 0; data = '0; ce_s = 0; clr_s = 0; data_s = '0;
    RST = 0;
    #2 RST = 1;
    #2;
    chk("rst valid", valid, 0);
    chk("rst match", match, 0);
    chk("rst locked", locked, 0);
    chk("rst cnts", {wc, ew, eb}, '0);
    chk("rst sat cnts", {valid_s, locked_s, wc_s, ew_s, eb_s}, '0);
    @(posedge REC_CLK); @(posedge REC_CLK); #1;
    RST = 0;

    t = SEED;
    next_word(t, w);
    chk("model E0", w, 48'h83B62E_076C5C);

    m = SEED;
    foreach (rows[i]) begin
      case (rows[i].kind)
        KS: begin ce = 1; data = START; m = SEED; end
        KG: begin ce = 1; next_word(m, w); data = w ^ rows[i].mask; end
        default: begin ce = 0; data = '0; end
      endcase
      #1;
      chk($sformatf("row%0d strt", i), strt, logic'(rows[i].kind == KS));
      @(posedge REC_CLK); #1;
      chk($sformatf("row%0d valid", i), valid, rows[i].ev);
      chk($sformatf("row%0d match", i), match, rows[i].em);
      chk($sformatf("row%0d locked", i), locked, rows[i].el);
      if (rows[i].cc) begin
        chk($sformatf("row%0d word_cnt", i), wc, rows[i].wc);
        chk($sformatf("row%0d err_words", i), ew, rows[i].ew);
        chk($sformatf("row%0d err_bits", i), eb, rows[i].eb);
      end
    end
    ce = 0;

    // Scenario 5: saturation and clear (CNT_W=4, LOSS_THR=15), staying in ACQ
    ms = SEED;
    drive_s(1, START, 0);
    repeat (10) begin next_word(ms, w); drive_s(1, w ^ 48'h1, 0); end
    drive_s(0, '0, 0);
    chk("sat10 valid", valid_s, 1);
    chk("sat10 locked", locked_s, 0);
    chk("sat10 cnts", {wc_s, ew_s, eb_s}, 12'hAAA);
    ms = SEED;
    drive_s(1, START, 0);
    repeat (10) begin next_word(ms, w); drive_s(1, w ^ 48'h1, 0); end
    drive_s(0, '0, 0);
    chk("sat20 locked", locked_s, 0);
    chk("sat20 word_cnt", wc_s, 4'hF);
    chk("sat20 err_words", ew_s, 4'hF);
    chk("sat20 err_bits", eb_s, 4'hF);
    next_word(ms, w);
    drive_s(1, w ^ 48'h1, 0);
    drive_s(0, '0, 1);
    chk("clr valid", valid_s, 1);
    chk("clr match", match_s, 0);
    chk("clr cnts", {wc_s, ew_s, eb_s}, 12'h000);
    next_word(ms, w);
    drive_s(1, w, 0);
    drive_s(0, '0, 0);
    chk("post-clr valid", valid_s, 1);
    chk("post-clr match", match_s, 1);
    chk("post-clr locked", locked_s, 1);
    chk("post-clr cnts", {wc_s, ew_s, eb_s}, 12'h100);

    // Scenario 6: sparse CE, async reset between sampling and compare edges
    m = SEED;
    drive(1, START);
    drive(0, '0);
    drive(0, '0);
    next_word(m, w);
    drive(1, w);
    drive(0, '0);
    chk("sparse valid", valid, 1);
    chk("sparse match", match, 1);
    chk("sparse locked", locked, 1);
    drive(0, '0);
    next_word(m, w);
    drive(1, w);
    RST = 1;
    #1;
    chk("async valid", valid, 0);
    chk("async match", match, 0);
    chk("async locked", locked, 0);
    chk("async cnts", {wc, ew, eb}, '0);
    #1 RST = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, '0);
      chk($sformatf("post-rst%0d valid", i), valid, 0);
    end
    t = SEED;
    next_word(t, w);
    drive(1, w);
    for (int i = 0; i < 3; i++) begin
      drive(0, '0);
      chk($sformatf("hunt%0d valid", i), valid, 0);
      chk($sformatf("hunt%0d locked", i), locked, 0);
    end
    chk("hunt cnts", {wc, ew, eb}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_rx_chk.md
# prbs_rx_chk

Parametrised PRBS receive checker for the mezzanine link test path. It is the successor to the fixed 48-bit/24-bit receiver, which only compared data against the LFSR. Beyond that comparison, this block:
- sequences lock acquisition and loss with a state machine;
- resynchronises on the start pattern without dropping lock;
- keeps saturating word, errored-word and bit-error counters for software readout.

It sits between the deserialiser output register and the test-status register bank, in the REC_CLK domain.

## Interface
Parameters:
- DATA_W, 48: received word width; must be an integer multiple of LFSR_W.
- LFSR_W, 24: LFSR length.
- TAPS, 24'hE10000: Fibonacci tap mask. Bit i set means state bit i feeds the XOR. The default is polynomial [24,23,22,17].
- SEED, 24'h83B62E: LFSR state loaded on start pattern.
- START_PAT, 48'hFFFFFF000000: sync word.
- LOSS_THR, 4: consecutive mismatched words that cause loss of sync (1..15).
- CNT_W, 32: counter width.

Ports:
- REC_CLK, in, 1: receive clock; all logic is on its rising edge.
- RST, in, 1: asynchronous, active-high reset.
- CE, in, 1: word strobe; RCV_DATA is sampled only on cycles with CE=1.
- CLR_CNT, in, 1: synchronous clear of all counters.
- RCV_DATA, in, DATA_W: received word.
- STRT_MTCH, out, 1: combinational, RCV_DATA==START_PAT.
- VALID, out, 1: one-clock strobe marking a checked word result.
- MATCH, out, 1: result of the last checked word; held between VALIDs.
- LOCKED, out, 1: high in state LOCK.
- WORD_CNT, out, CNT_W: number of checked words.
- ERR_WORDS, out, CNT_W: number of mismatched checked words.
- ERR_BITS, out, CNT_W: sum of popcount(received XOR expected).

## Operation
- K = DATA_W/LFSR_W LFSR steps per word.
- LFSR step: shift left by one; bit0 = XOR of the state bits selected by TAPS.
- S[0]=SEED, S[i+1]=step(S[i]).
- Expected word n after a start pattern: E_n = {S[nK], …, S[nK+K-1]}, with S[nK] in the MSBs.
- The K steps per word are unrolled combinationally, and the LFSR advances K steps per checked CE.
- A CE word equal to START_PAT, in any state:
  - reloads the LFSR to SEED;
  - is not checked (no VALID);
  - leaves the next non-start CE word expected as E_0.
- Consecutive start patterns each reload.
- FSM states: HUNT, ACQ, LOCK. Reset state is HUNT.
  - HUNT: words are ignored and produce no VALID. Start pattern → ACQ.
  - ACQ: every non-start word is checked. A MATCH → LOCK. LOSS_THR consecutive mismatches → HUNT.
  - LOCK: checks continue. LOSS_THR consecutive mismatches → HUNT. A start pattern resyncs and stays in LOCK.
- The consecutive-mismatch counter clears on any match, on a start pattern, and on entering HUNT.
- Counters update on each VALID and saturate at all-ones (no wrap). WORD_CNT increments by 1, ERR_WORDS increments by 1 on mismatch, and ERR_BITS adds the popcount (0..DATA_W), saturating.
- CLR_CNT clears the counters only; FSM and LFSR are unaffected. If CLR_CNT coincides with an update, the clear wins and that update is dropped.

## Timing
- Stage 1, on a CE edge: register RCV_DATA and E_n, and mark the stage as occupied.
- Stage 2, the next clock edge (not CE-gated): compare, then update VALID, MATCH, the counters, the FSM and the mismatch counter.
- Latency is 2 edges from the sampling edge to VALID. VALID is high for exactly one clock.
- Back-to-back CE on every clock is supported, giving one VALID per clock.
- LOCKED changes on the same edge as the VALID that causes the transition.
- When the FSM enters HUNT, any word occupying stage 1 is discarded and gives no VALID.
- Reset values: VALID=0, MATCH=0, LOCKED=0, all counters 0, FSM HUNT, stage 1 empty, LFSR=SEED.
- RST mid-operation clears everything immediately (asynchronous). In-flight words produce no VALID.

## Test plan
1. **Reset then acquire.** Stimulus: RST, then START_PAT, then 48'h83B62E_076C5C (E_0) and 99 further correct words, with CE every clock. Required: STRT_MTCH=1 on the start cycle; the first VALID 2 clocks after E_0 is sampled, with MATCH=1; LOCKED rises on that edge; final WORD_CNT=100, ERR_WORDS=0, ERR_BITS=0.
2. **Bit errors.** Stimulus: while locked, flip 3 bits in one word. Required: that VALID has MATCH=0; ERR_WORDS=1, ERR_BITS=3; LOCKED stays 1; the next correct word gives MATCH=1.
3. **Loss of lock.** Stimulus: 4 consecutive corrupted words. Required: LOCKED falls on the 4th VALID; after that, no VALID until the next START_PAT; re-acquire as in scenario 1.
4. **Resync while locked.** Stimulus: START_PAT mid-stream, then E_0. Required: no VALID for the start word; LOCKED stays 1; MATCH=1 on E_0.
5. **Counter clear and saturation.** Stimulus: CNT_W=4 with 20 errored words (ACQ state, LOSS_THR=15), then CLR_CNT coincident with a VALID. Required: ERR_WORDS holds at 4'hF; after the clear, all counters are 0 and the coincident update is dropped.
6. **Async reset mid-stream with sparse CE.** Stimulus: CE every 3rd clock; assert RST between the sampling edge and the compare edge. Required: no VALID; all outputs 0; FSM in HUNT.
